// File: rtl/wb_ahb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// wb_ahb_pkg
// Shared definitions for the Wishbone-classic to AHB-Lite bridge:
//   - AHB HTRANS / HSIZE encodings
//   - bridge FSM state type
//   - select-decode result struct
//   - read data returned when the data-phase watchdog fires
// No ports (package).
// -----------------------------------------------------------------------------
package wb_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ACK
   } state_t;

   // Byte-lane select translated into an AHB transfer shape.
   typedef struct packed {
      logic       legal;
      logic [2:0] hsize;
      logic [1:0] addr_lsb;
   } sel_dec_t;

endpackage

// File: rtl/wb_ahb_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_ahb_bridge_if
// Bundles the Wishbone slave port, the AHB-Lite master port and the error
// flag of the bridge.
//   master modport : bridge side (Wishbone slave in, AHB-Lite master out)
//   slave  modport : environment side (Wishbone master + AHB-Lite slave)
// Signals:
//   wbs_cyc_i/stb_i/we_i, wbs_sel_i[3:0], wbs_adr_i/dat_i[31:0] -> bridge
//   wbs_ack_o, wbs_dat_o[31:0]                                  <- bridge
//   HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HWRITE, HWDATA[31:0]  <- bridge
//   HRDATA[31:0], HREADY, HRESP                                 -> bridge
//   err_clr_i -> bridge, err_o <- bridge
// -----------------------------------------------------------------------------
interface wb_ahb_bridge_if;

   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   logic        err_clr_i;
   logic        err_o;

   modport master (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
      input  HRDATA, HREADY, HRESP,
      input  err_clr_i,
      output err_o
   );

   modport slave (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
      output HRDATA, HREADY, HRESP,
      output err_clr_i,
      input  err_o
   );

endinterface

// File: rtl/wb_ahb_bridge_sel_decode.sv
// -----------------------------------------------------------------------------
// wb_ahb_sel_decode
// Combinational translation of a Wishbone byte-lane select into an AHB
// transfer: legal flag, HSIZE and the low two address bits.
//   i_sel[3:0]  in   Wishbone byte-lane select
//   o_dec       out  {legal, hsize[2:0], addr_lsb[1:0]}
// Only naturally aligned word, halfword and byte patterns are legal.
// -----------------------------------------------------------------------------
module wb_ahb_sel_decode
   import wb_ahb_pkg::*;
(
   input  logic [3:0] i_sel,
   output sel_dec_t   o_dec
);

   always_comb begin
      // NOTE: default assignment first so every path drives o_dec (no latch).
      o_dec = '{legal: 1'b0, hsize: HSIZE_BYTE, addr_lsb: 2'b00};
      case (i_sel)
         4'b1111: o_dec = '{legal: 1'b1, hsize: HSIZE_WORD, addr_lsb: 2'b00};
         4'b0011: o_dec = '{legal: 1'b1, hsize: HSIZE_HALF, addr_lsb: 2'b00};
         4'b1100: o_dec = '{legal: 1'b1, hsize: HSIZE_HALF, addr_lsb: 2'b10};
         4'b0001: o_dec = '{legal: 1'b1, hsize: HSIZE_BYTE, addr_lsb: 2'b00};
         4'b0010: o_dec = '{legal: 1'b1, hsize: HSIZE_BYTE, addr_lsb: 2'b01};
         4'b0100: o_dec = '{legal: 1'b1, hsize: HSIZE_BYTE, addr_lsb: 2'b10};
         4'b1000: o_dec = '{legal: 1'b1, hsize: HSIZE_BYTE, addr_lsb: 2'b11};
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_ahb_bridge.sv
// -----------------------------------------------------------------------------
// wb_ahb_bridge
// Wishbone-classic slave to AHB-Lite master bridge. One outstanding single
// beat transfer; byte-lane selects become HSIZE plus HADDR[1:0].
// Ports:
//   wb_clk_i  in  clock for both the Wishbone and AHB sides
//   wb_rst_i  in  asynchronous active-high reset
//   bus       wb_ahb_bridge_if.master (Wishbone slave, AHB master, err flag)
// Parameters:
//   WB_BASE        Wishbone window, matched on wbs_adr_i[31:24]
//   AHB_BASE       upper byte of HADDR
//   TIMEOUT_CYCLES data-phase watchdog limit
// Optional feature macro: WB_AHB_BRIDGE_TIMEOUT_EN enables the data-phase
// watchdog; without it DATA waits on HREADY indefinitely.
// All outputs are registered.
// -----------------------------------------------------------------------------
module wb_ahb_bridge
   import wb_ahb_pkg::*;
#(
   parameter logic [31:0] WB_BASE        = 32'h3000_0000,
   parameter logic [31:0] AHB_BASE       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   wb_ahb_bridge_if.master bus
);

   state_t      r_state;
   logic        r_abort;     // cyc dropped mid-transfer: finish AHB, no ack
   logic [31:0] r_haddr;
   logic [1:0]  r_htrans;
   logic [2:0]  r_hsize;
   logic        r_hwrite;
   logic [31:0] r_hwdata;
   logic        r_ack;
   logic [31:0] r_rdata;
   logic        r_err;

   sel_dec_t    w_dec;
   logic        w_hit;
   logic        w_req;

`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] r_to_cnt;
   // After a timeout the slave may still be stalled; hold off new requests
   // until it has shown HREADY high again.
   logic            r_hready_seen;
`endif

   wb_ahb_sel_decode u_sel_decode (
      .i_sel (bus.wbs_sel_i),
      .o_dec (w_dec)
   );

   assign w_hit = (bus.wbs_adr_i[31:24] == WB_BASE[31:24]);
`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
   assign w_req = bus.wbs_cyc_i & bus.wbs_stb_i & w_hit & r_hready_seen;
`else
   assign w_req = bus.wbs_cyc_i & bus.wbs_stb_i & w_hit;
`endif

   // NOTE: asynchronous reset in the sensitivity list so outputs drop to their
   // idle values the moment wb_rst_i rises, without waiting for a clock.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state  <= ST_IDLE;
         r_abort  <= 1'b0;
         r_haddr  <= '0;
         r_htrans <= HTRANS_IDLE;
         r_hsize  <= '0;
         r_hwrite <= 1'b0;
         r_hwdata <= '0;
         r_ack    <= 1'b0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
         r_to_cnt      <= '0;
         r_hready_seen <= 1'b1;
`endif
      end else begin
         // NOTE: non-blocking, last assignment wins: a set of r_err further
         // down overrides this clear, giving set priority over err_clr_i.
         if (bus.err_clr_i) r_err <= 1'b0;
`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
         if (bus.HREADY) r_hready_seen <= 1'b1;
`endif

         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_abort <= 1'b0;
                  if (w_dec.legal) begin
                     r_haddr  <= {AHB_BASE[31:24], bus.wbs_adr_i[23:2], w_dec.addr_lsb};
                     r_hsize  <= w_dec.hsize;
                     r_hwrite <= bus.wbs_we_i;
                     r_hwdata <= bus.wbs_dat_i;
                     r_htrans <= HTRANS_NONSEQ;
                     r_state  <= ST_ADDR;
                  end else begin
                     // Illegal lane pattern: answer immediately, no AHB access.
                     r_ack   <= 1'b1;
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                     r_state <= ST_ACK;
                  end
               end
            end

            ST_ADDR: begin
               if (!bus.wbs_cyc_i) r_abort <= 1'b1;
               if (bus.HREADY) begin
                  r_htrans <= HTRANS_IDLE;
                  r_state  <= ST_DATA;
`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end

            ST_DATA: begin
               if (!bus.wbs_cyc_i) r_abort <= 1'b1;
               if (bus.HREADY) begin
                  if (bus.HRESP) r_err <= 1'b1;
                  if (r_abort || !bus.wbs_cyc_i) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_ack   <= 1'b1;
                     r_rdata <= (bus.HRESP || r_hwrite) ? 32'h0 : bus.HRDATA;
                     r_state <= ST_ACK;
                  end
               end
`ifdef WB_AHB_BRIDGE_TIMEOUT_EN
               else if (r_to_cnt == TO_LAST) begin
                  r_err         <= 1'b1;
                  r_hready_seen <= 1'b0;
                  if (r_abort || !bus.wbs_cyc_i) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_ack   <= 1'b1;
                     r_rdata <= TIMEOUT_DATA;
                     r_state <= ST_ACK;
                  end
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
`endif
            end

            ST_ACK: begin
               // Strobe is deliberately ignored here so a request held until
               // the ack edge is not issued a second time.
               r_ack   <= 1'b0;
               r_rdata <= '0;
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.HADDR     = r_haddr;
   assign bus.HTRANS    = r_htrans;
   assign bus.HSIZE     = r_hsize;
   assign bus.HWRITE    = r_hwrite;
   assign bus.HWDATA    = r_hwdata;
   assign bus.wbs_ack_o = r_ack;
   assign bus.wbs_dat_o = r_rdata;
   assign bus.err_o     = r_err;

endmodule
